// File: rtl/reg_acc_arb_if.sv
// Register-access arbiter signal bundle: two requester ports plus the shared register bus.
// slave = arbiter view, master = environment view (requesters and register bank).
interface reg_acc_arb_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic          i_m0_req;
  logic          i_m0_wr;
  logic [AW-1:0] i_m0_addr;
  logic [DW-1:0] i_m0_wdata;
  logic          o_m0_ack;
  logic [DW-1:0] o_m0_rdata;

  logic          i_m1_req;
  logic          i_m1_wr;
  logic [AW-1:0] i_m1_addr;
  logic [DW-1:0] i_m1_wdata;
  logic          o_m1_ack;
  logic [DW-1:0] o_m1_rdata;

  logic          o_reg_ren;
  logic          o_reg_wen;
  logic [AW-1:0] o_reg_addr;
  logic [DW-1:0] o_reg_wdata;
  logic [DW-1:0] i_reg_rdata;
  logic          o_busy;

  modport slave (
    input  i_m0_req, i_m0_wr, i_m0_addr, i_m0_wdata,
    input  i_m1_req, i_m1_wr, i_m1_addr, i_m1_wdata,
    input  i_reg_rdata,
    output o_m0_ack, o_m0_rdata, o_m1_ack, o_m1_rdata,
    output o_reg_ren, o_reg_wen, o_reg_addr, o_reg_wdata, o_busy
  );

  modport master (
    output i_m0_req, i_m0_wr, i_m0_addr, i_m0_wdata,
    output i_m1_req, i_m1_wr, i_m1_addr, i_m1_wdata,
    output i_reg_rdata,
    input  o_m0_ack, o_m0_rdata, o_m1_ack, o_m1_rdata,
    input  o_reg_ren, o_reg_wen, o_reg_addr, o_reg_wdata, o_busy
  );
endinterface

// File: rtl/reg_acc_arb.sv
// Shares the register bus between the SPI decoder (m0) and the trim/OTP loader (m1):
// round-robin grant, then a fixed IDLE -> ACCESS -> ACK sequence with registered outputs.
module reg_acc_arb #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  reg_acc_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t        state_q, state_d;
  logic          last_grant;
  logic          gnt_p0;
  logic          wr_p0;
  logic [AW-1:0] addr_p0;
  logic [DW-1:0] wdata_p0;

  logic          ren_q, wen_q, ack0_q, ack1_q, busy_q;
  logic [DW-1:0] rdata0_q, rdata1_q;

  logic          ren_d, wen_d, ack0_d, ack1_d, take;
  logic [DW-1:0] rdata0_d, rdata1_d;

  // m1 wins when it is the only requester, or on contention when m0 had the last grant.
  logic          any_req, win_m1, sel_wr;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  assign any_req   = bus.i_m0_req | bus.i_m1_req;
  assign win_m1    = bus.i_m1_req & (~bus.i_m0_req | ~last_grant);
  assign sel_wr    = win_m1 ? bus.i_m1_wr    : bus.i_m0_wr;
  assign sel_addr  = win_m1 ? bus.i_m1_addr  : bus.i_m0_addr;
  assign sel_wdata = win_m1 ? bus.i_m1_wdata : bus.i_m0_wdata;

  always_comb begin
    state_d  = state_q;
    take     = 1'b0;
    ren_d    = 1'b0;
    wen_d    = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = '0;
    rdata1_d = '0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          take    = 1'b1;
          ren_d   = ~sel_wr;
          wen_d   = sel_wr;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Read data is sampled at the end of the strobe cycle and steered to the winner only.
        ack0_d  = ~gnt_p0;
        ack1_d  = gnt_p0;
        if (!wr_p0 && !gnt_p0) rdata0_d = bus.i_reg_rdata;
        if (!wr_p0 &&  gnt_p0) rdata1_d = bus.i_reg_rdata;
        state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: grant latch; bus and ack registers update alongside.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      last_grant <= 1'b1;
      gnt_p0     <= 1'b0;
      wr_p0      <= 1'b0;
      addr_p0    <= '0;
      wdata_p0   <= '0;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      busy_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q  <= state_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      busy_q   <= (state_d != IDLE);
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      if (take) begin
        last_grant <= win_m1;
        gnt_p0     <= win_m1;
        wr_p0      <= sel_wr;
        addr_p0    <= sel_addr;
        wdata_p0   <= sel_wdata;
      end
    end
  end

  assign bus.o_reg_ren   = ren_q;
  assign bus.o_reg_wen   = wen_q;
  assign bus.o_reg_addr  = addr_p0;
  assign bus.o_reg_wdata = wdata_p0;
  assign bus.o_m0_ack    = ack0_q;
  assign bus.o_m1_ack    = ack1_q;
  assign bus.o_m0_rdata  = rdata0_q;
  assign bus.o_m1_rdata  = rdata1_q;
  assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_reg_acc_arb.sv
// Bench for reg_acc_arb: requester drivers push expected responses per requester; a
// cycle-level monitor applies the round-robin and 3-phase timing rules and compares.
module tb_reg_acc_arb;

  logic clk;
  logic rst_n;

  reg_acc_arb_if #(.DW(8), .AW(8)) ifc ();

  reg_acc_arb #(.DW(8), .AW(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } txn_t;

  txn_t q0[$];
  txn_t q1[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Register bank contents: 0x12 holds 0xA5, the top quarter of the map is unmapped (reads 0).
  function automatic logic [7:0] ref_rd(input logic [7:0] a);
    if (a == 8'h12) return 8'hA5;
    if (a[7:6] == 2'b11) return 8'h00;
    return (a ^ 8'h5A) + 8'h11;
  endfunction

  always_comb begin
    ifc.i_reg_rdata = 8'h00;
    if (ifc.o_reg_ren) ifc.i_reg_rdata = ref_rd(ifc.o_reg_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic r, input logic wr,
                         input logic [7:0] a, input logic [7:0] d);
    if (id == 0) begin
      ifc.i_m0_req = r; ifc.i_m0_wr = wr; ifc.i_m0_addr = a; ifc.i_m0_wdata = d;
    end else begin
      ifc.i_m1_req = r; ifc.i_m1_wr = wr; ifc.i_m1_addr = a; ifc.i_m1_wdata = d;
    end
  endtask

  function automatic logic get_ack(input int id);
    return (id == 0) ? ifc.o_m0_ack : ifc.o_m1_ack;
  endfunction

  task automatic push_exp(input int id, input logic wr, input logic [7:0] a, input logic [7:0] d);
    txn_t t;
    t.wr    = wr;
    t.addr  = a;
    t.wdata = d;
    t.rdata = wr ? 8'h00 : ref_rd(a);
    if (id == 0) q0.push_back(t);
    else         q1.push_back(t);
  endtask

  // Issues n accesses from requester id; keeps req high across accesses when chaining.
  task automatic run_master(input int id, input int n, input bit rnd, input logic wr_f,
                            input logic [7:0] a_f, input logic [7:0] d_f, input bit early);
    logic       wr;
    logic [7:0] a, d;
    bit         keep;
    int         w;
    for (int k = 0; k < n; k++) begin
      wr = rnd ? logic'($urandom_range(0, 1)) : wr_f;
      a  = rnd ? 8'($urandom_range(0, 255)) : 8'(a_f + 8'(k));
      d  = rnd ? 8'($urandom_range(0, 255)) : 8'(d_f + 8'(k));
      push_exp(id, wr, a, d);
      set_req(id, 1'b1, wr, a, d);
      if (early) begin
        tick();
        set_req(id, 1'b0, 1'b0, 8'h00, 8'h00);
      end
      w = 0;
      do begin
        tick();
        w++;
      end while (!get_ack(id) && w < 30);
      if (!get_ack(id)) begin
        n_vec++;
        n_fail++;
        $display("FAIL ack_timeout m%0d: ack=0 after %0d cycles, required ack=1", id, w);
      end
      keep = rnd ? bit'($urandom_range(0, 1)) : (k < n - 1);
      if (k == n - 1) keep = 1'b0;
      if (!keep) begin
        set_req(id, 1'b0, 1'b0, 8'h00, 8'h00);
        if (rnd) repeat ($urandom_range(1, 3)) tick();
      end
    end
  endtask

  // Monitor: phase 0 = IDLE, 1 = expect strobe, 2 = expect ack.
  initial begin
    int   phase;
    int   win;
    int   last;
    txn_t t;
    phase = 0;
    win   = 0;
    last  = 1;
    t     = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        phase = 0;
        last  = 1;
      end else begin
        case (phase)
          0: begin
            chk("idle_outputs", 32'({ifc.o_reg_ren, ifc.o_reg_wen, ifc.o_m0_ack,
                                     ifc.o_m1_ack, ifc.o_busy}), 32'h0);
            if (ifc.i_m0_req || ifc.i_m1_req) begin
              if (ifc.i_m0_req && ifc.i_m1_req) win = (last == 1) ? 0 : 1;
              else                              win = ifc.i_m0_req ? 0 : 1;
              last  = win;
              phase = 1;
            end
          end
          1: begin
            if ((win == 0 && q0.size() == 0) || (win == 1 && q1.size() == 0)) begin
              n_vec++;
              n_fail++;
              $display("FAIL no_expected m%0d: granted with empty queue, required pending entry", win);
              t = '0;
            end else begin
              t = (win == 0) ? q0[0] : q1[0];
            end
            chk("access_busy", 32'(ifc.o_busy), 32'h1);
            chk("access_strobes", 32'({ifc.o_reg_ren, ifc.o_reg_wen}), 32'({~t.wr, t.wr}));
            chk("access_addr", 32'(ifc.o_reg_addr), 32'(t.addr));
            if (t.wr) chk("access_wdata", 32'(ifc.o_reg_wdata), 32'(t.wdata));
            chk("access_acks", 32'({ifc.o_m0_ack, ifc.o_m1_ack}), 32'h0);
            phase = 2;
          end
          default: begin
            chk("ack_pulse", 32'({ifc.o_m0_ack, ifc.o_m1_ack}), (win == 0) ? 32'h2 : 32'h1);
            chk("ack_rdata", 32'((win == 0) ? ifc.o_m0_rdata : ifc.o_m1_rdata), 32'(t.rdata));
            chk("other_rdata", 32'((win == 0) ? ifc.o_m1_rdata : ifc.o_m0_rdata), 32'h0);
            chk("ack_strobes_busy", 32'({ifc.o_reg_ren, ifc.o_reg_wen, ifc.o_busy}), 32'h1);
            if (win == 0 && q0.size() > 0) void'(q0.pop_front());
            if (win == 1 && q1.size() > 0) void'(q1.pop_front());
            phase = 0;
          end
        endcase
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) tick();
    chk("reset_outputs", 32'({ifc.o_reg_ren, ifc.o_reg_wen, ifc.o_m0_ack, ifc.o_m1_ack,
                             ifc.o_busy}), 32'h0);
    chk("reset_addr_wdata", 32'({ifc.o_reg_addr, ifc.o_reg_wdata}), 32'h0);
    chk("reset_rdata", 32'({ifc.o_m0_rdata, ifc.o_m1_rdata}), 32'h0);
    rst_n = 1'b1;
    repeat (2) tick();

    run_master(0, 1, 1'b0, 1'b0, 8'h12, 8'h00, 1'b0);
    repeat (2) tick();
    run_master(1, 1, 1'b0, 1'b1, 8'h40, 8'h3C, 1'b0);
    repeat (2) tick();
    run_master(1, 1, 1'b0, 1'b0, 8'hC5, 8'h00, 1'b0);
    repeat (2) tick();

    fork
      run_master(0, 4, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0);
      run_master(1, 4, 1'b0, 1'b1, 8'h80, 8'h90, 1'b0);
    join
    repeat (2) tick();

    run_master(0, 1, 1'b0, 1'b0, 8'h33, 8'h00, 1'b1);
    repeat (4) tick();
    run_master(1, 2, 1'b0, 1'b0, 8'h60, 8'h00, 1'b0);
    repeat (2) tick();

    // Abort an m0 access mid-strobe; m0 must still win the next contention.
    push_exp(0, 1'b1, 8'h77, 8'hEE);
    set_req(0, 1'b1, 1'b1, 8'h77, 8'hEE);
    begin
      int w;
      w = 0;
      do begin
        tick();
        w++;
      end while (!ifc.o_reg_wen && w < 10);
    end
    chk("abort_strobe_seen", 32'(ifc.o_reg_wen), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", 32'({ifc.o_reg_ren, ifc.o_reg_wen, ifc.o_m0_ack, ifc.o_m1_ack,
                             ifc.o_busy}), 32'h0);
    chk("abort_addr", 32'(ifc.o_reg_addr), 32'h0);
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    q0.delete();
    q1.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    fork
      run_master(0, 1, 1'b0, 1'b0, 8'h21, 8'h00, 1'b0);
      run_master(1, 1, 1'b0, 1'b1, 8'h55, 8'h66, 1'b0);
    join
    repeat (2) tick();

    fork
      run_master(0, 40, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      run_master(1, 40, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    join
    repeat (4) tick();
    chk("final_q0_empty", 32'(q0.size()), 32'h0);
    chk("final_q1_empty", 32'(q1.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
